// File: rtl/padded_row_window_buffer_if.sv
// padded_row_window_buffer_if: row-in / K-row-window-out handshake bundle
// Ports (signals):
//   in_row, in_valid, in_ready          : one packed image row per handshake
//   out_rows, out_valid, out_ready      : K-row padded window per handshake
//   out_row_idx                         : padded-row index of the window's top row
// Modports: master = upstream/downstream environment, slave = the window buffer.
interface padded_row_window_buffer_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int CH     = 3,
    parameter int PAD    = 1,
    parameter int K      = 3
);
    localparam int PW   = IMG_W + 2 * PAD;
    localparam int RW   = CH * PW * DATA_W;
    localparam int NOUT = IMG_H + 2 * PAD - K + 1;
    localparam int IW   = $clog2(NOUT + 1);

    logic [CH*IMG_W*DATA_W-1:0] in_row;
    logic                       in_valid;
    logic                       in_ready;
    logic [K*RW-1:0]            out_rows;
    logic                       out_valid;
    logic                       out_ready;
    logic [IW-1:0]              out_row_idx;

    modport master (
        output in_row, in_valid, out_ready,
        input  in_ready, out_rows, out_valid, out_row_idx
    );

    modport slave (
        input  in_row, in_valid, out_ready,
        output in_ready, out_rows, out_valid, out_row_idx
    );
endinterface

// File: rtl/padded_row_window_buffer.sv
// padded_row_window_buffer: pads image rows/columns and streams a K-row sliding window
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   start       : frame start pulse, honoured in IDLE only
//   clear       : synchronous abort back to IDLE, highest priority
//   pad_value   : border pixel value sampled on start (only when PAD_VALUE_EN is defined)
//   frame_done  : one-cycle pulse after the last window of a frame is consumed
//   bus         : row input / window output handshakes (padded_row_window_buffer_if.slave)
// Optional feature macro: PAD_VALUE_EN (undefined: border pixels are 0, no pad_value port).
module padded_row_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int CH     = 3,
    parameter int PAD    = 1,
    parameter int K      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear,
`ifdef PAD_VALUE_EN
    input  logic [DATA_W-1:0]          pad_value,
`endif
    output logic                       frame_done,
    padded_row_window_buffer_if.slave  bus
);
    localparam int PW   = IMG_W + 2 * PAD;
    localparam int RW   = CH * PW * DATA_W;
    localparam int NOUT = IMG_H + 2 * PAD - K + 1;
    localparam int IW   = $clog2(NOUT + 1);
    localparam int FW   = $clog2(K + 1);
    localparam int CW   = $clog2(IMG_H + PAD + 1);

    typedef enum logic [2:0] {IDLE, TOP, ROWS, BOT, DRAIN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [FW-1:0]   fill;
    logic [IW-1:0]   idx;
    logic [K*RW-1:0] rows, shifted;
    logic [RW-1:0]   in_padded, new_row;
    logic [DATA_W-1:0] pad_px;
    logic            valid, permit, push, consume, last, phase_end;
    int              phase_len;

`ifdef PAD_VALUE_EN
    logic [DATA_W-1:0] pad_q;
    assign pad_px = pad_q;
`else
    assign pad_px = '0;
`endif

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar x = 0; x < PW; x++) begin : g_col
            if (x < PAD || x >= PAD + IMG_W) begin : g_pad
                assign in_padded[(c*PW+x)*DATA_W +: DATA_W] = pad_px;
            end else begin : g_pix
                assign in_padded[(c*PW+x)*DATA_W +: DATA_W] = bus.in_row[(c*IMG_W+x-PAD)*DATA_W +: DATA_W];
            end
        end
    end

    // Shift up: row 0 falls off the bottom of the vector, the new row enters at row K-1.
    if (K == 1) begin : g_one
        assign shifted = new_row;
    end else begin : g_many
        assign shifted = {new_row, rows[K*RW-1:RW]};
    end

    assign new_row   = state == ROWS ? in_padded : {CH*PW{pad_px}};
    assign permit    = !valid || bus.out_ready;
    assign consume   = valid && bus.out_ready;
    assign last      = int'(idx) == NOUT - 1;
    assign push      = (state == TOP || state == BOT) ? permit : state == ROWS ? bus.in_valid && permit : 1'b0;
    assign phase_len = state == ROWS ? IMG_H : PAD;
    assign phase_end = push && int'(cnt) == phase_len - 1;

    assign bus.in_ready    = state == ROWS && permit;
    assign bus.out_valid   = valid;
    assign bus.out_rows    = rows;
    assign bus.out_row_idx = idx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PAD > 0 ? TOP : ROWS;
            TOP:     if (phase_end) state_nx = ROWS;
            ROWS:    if (phase_end) state_nx = PAD > 0 ? BOT : DRAIN;
            BOT:     if (phase_end) state_nx = DRAIN;
            DRAIN:   if (consume && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fill       <= '0;
            idx        <= '0;
            rows       <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
`ifdef PAD_VALUE_EN
            pad_q      <= '0;
`endif
        end else if (clear) begin
            state      <= IDLE;
            cnt        <= '0;
            fill       <= '0;
            idx        <= '0;
            rows       <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
`ifdef PAD_VALUE_EN
            pad_q      <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                cnt  <= '0;
                fill <= '0;
                idx  <= '0;
            end else begin
                // Push counter restarts at every phase boundary (TOP->ROWS->BOT).
                cnt <= phase_end ? '0 : cnt + CW'(push);
                if (push && int'(fill) < K) fill <= fill + FW'(1);
                if (consume) idx <= last ? '0 : idx + IW'(1);
            end
            if (push) rows <= shifted;
            // A push completing the K-th row makes a window; consume+push keeps valid high.
            valid      <= (push && int'(fill) >= K - 1) || (valid && !consume);
            frame_done <= state == DRAIN && consume && last;
`ifdef PAD_VALUE_EN
            if (state == IDLE && start) pad_q <= pad_value;
`endif
        end
    end
endmodule

// File: tb/tb_padded_row_window_buffer.sv
// tb_padded_row_window_buffer: self-checking bench for padded_row_window_buffer
module tb_padded_row_window_buffer;
    localparam int DATA_W = 8, IMG_W = 4, IMG_H = 4, CH = 3, PAD = 1, K = 3;
    localparam int PW = IMG_W + 2 * PAD;
    localparam int RW = CH * PW * DATA_W;
    localparam int NOUT = IMG_H + 2 * PAD - K + 1;
    localparam int IW = $clog2(NOUT + 1);
    localparam int INW = CH * IMG_W * DATA_W;

    logic clk = 0, reset = 1, start = 0, clear = 0;
    logic frame_done;
`ifdef PAD_VALUE_EN
    logic [DATA_W-1:0] pad_value = '0;
`endif

    padded_row_window_buffer_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PAD(PAD), .K(K)) bus ();

    padded_row_window_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PAD(PAD), .K(K)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .clear(clear),
`ifdef PAD_VALUE_EN
        .pad_value(pad_value),
`endif
        .frame_done(frame_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0, n_fail = 0;
    logic [DATA_W-1:0] img [IMG_H][CH][IMG_W];
    logic [DATA_W-1:0] cur_pad = '0;
    logic [K*RW-1:0] got_rows[$];
    int got_idx[$];
    int got_cyc[$];
    int done_cnt, done_lag, rows_acc, first_valid, unstable, bad_ready, stall_seen;

    function automatic void fill_img(input bit rnd);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < CH; c++)
                for (int x = 0; x < IMG_W; x++)
                    img[r][c][x] = rnd ? DATA_W'($urandom) : DATA_W'(16 * r + x);
    endfunction

    function automatic logic [INW-1:0] pack_row(input int r);
        logic [INW-1:0] v = '0;
        for (int c = 0; c < CH; c++)
            for (int x = 0; x < IMG_W; x++)
                v[(c*IMG_W+x)*DATA_W +: DATA_W] = img[r][c][x];
        return v;
    endfunction

    // Window n = padded rows n..n+K-1 of the bordered image.
    function automatic logic [K*RW-1:0] exp_win(input int n);
        logic [K*RW-1:0] w = '0;
        logic [DATA_W-1:0] v;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < CH; c++)
                for (int x = 0; x < PW; x++) begin
                    int pr = n + r;
                    if (pr < PAD || pr >= PAD + IMG_H || x < PAD || x >= PAD + IMG_W) v = cur_pad;
                    else v = img[pr-PAD][c][x-PAD];
                    w[r*RW + (c*PW+x)*DATA_W +: DATA_W] = v;
                end
        return w;
    endfunction

    // vmode: 0 valid always, 1 alternate, 2 random (+ stray starts); rmode: 0 ready, 1 stall 5 at window1, 2 random
    task automatic run_frame(input int vmode, input int rmode, input int budget);
        int cyc = 0, last_cons = -100, done_cyc = -1;
        logic hold = 0;
        logic [K*RW-1:0] hold_rows = '0;
        logic [IW-1:0] hold_idx = '0;
        got_rows.delete(); got_idx.delete(); got_cyc.delete();
        done_cnt = 0; done_lag = -1; rows_acc = 0; first_valid = -1;
        unstable = 0; bad_ready = 0; stall_seen = 0;
`ifdef PAD_VALUE_EN
        pad_value = cur_pad;
`endif
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
`ifdef PAD_VALUE_EN
        pad_value = ~cur_pad;
`endif
        while (cyc < budget && (done_cyc < 0 || cyc < done_cyc + 4)) begin
            bus.in_valid = (vmode == 0) || (vmode == 1 && cyc % 2 == 0) || (vmode == 2 && $urandom_range(0, 1) == 1);
            bus.in_row = rows_acc < IMG_H ? pack_row(rows_acc) : ~pack_row(0);
            bus.out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (got_rows.size() != 1 || stall_seen >= 5) : $urandom_range(0, 2) != 0;
            start = vmode == 2 && got_rows.size() < NOUT && $urandom_range(0, 4) == 0;
            #1;
            if (hold && (!bus.out_valid || bus.out_rows !== hold_rows || bus.out_row_idx !== hold_idx)) unstable++;
            hold = bus.out_valid && !bus.out_ready;
            hold_rows = bus.out_rows;
            hold_idx = bus.out_row_idx;
            if (hold && bus.in_ready) bad_ready++;
            if (rmode == 1 && hold) stall_seen++;
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_lag = cyc - last_cons;
                end
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (bus.in_valid && bus.in_ready) rows_acc++;
            if (bus.out_valid && bus.out_ready) begin
                got_rows.push_back(bus.out_rows);
                got_idx.push_back(int'(bus.out_row_idx));
                got_cyc.push_back(cyc);
                last_cons = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0;
        bus.in_valid = 0;
        bus.out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        bus.in_valid = 1;
        bus.in_row = '1;
        bus.out_ready = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
        end
        reset = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b required 0", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.out_rows !== '0) begin n_fail++; $display("FAIL idle_out_rows: got %h required 0", bus.out_rows); end
        n_checks++;
        if (bus.out_row_idx !== '0) begin n_fail++; $display("FAIL idle_row_idx: got %0d required 0", bus.out_row_idx); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL idle_frame_done: got %b required 0", frame_done); end
        bus.in_valid = 0;
        bus.out_ready = 0;
    endtask

    task automatic test_full_frame();
        fill_img(0);
        run_frame(0, 0, 200);
        n_checks++;
        if (got_rows.size() != NOUT) begin n_fail++; $display("FAIL full_count: got %0d windows required %0d", got_rows.size(), NOUT); end
        for (int n = 0; n < got_rows.size() && n < NOUT; n++) begin
            n_checks++;
            if (got_rows[n] !== exp_win(n)) begin n_fail++; $display("FAIL full_win%0d: got %h required %h", n, got_rows[n], exp_win(n)); end
            n_checks++;
            if (got_idx[n] != n) begin n_fail++; $display("FAIL full_idx%0d: got %0d required %0d", n, got_idx[n], n); end
        end
        n_checks++;
        if (first_valid != K) begin n_fail++; $display("FAIL full_latency: got %0d required %0d", first_valid, K); end
        n_checks++;
        if (got_cyc.size() == NOUT && got_cyc[NOUT-1] - got_cyc[0] != NOUT - 1) begin
            n_fail++; $display("FAIL full_throughput: span %0d required %0d", got_cyc[NOUT-1] - got_cyc[0], NOUT - 1);
        end
        n_checks++;
        if (rows_acc != IMG_H) begin n_fail++; $display("FAIL full_rows_accepted: got %0d required %0d", rows_acc, IMG_H); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d required 1", done_cnt); end
        n_checks++;
        if (done_lag != 1) begin n_fail++; $display("FAIL full_done_lag: got %0d required 1", done_lag); end
    endtask

    task automatic test_backpressure();
        fill_img(1);
        run_frame(0, 1, 200);
        n_checks++;
        if (stall_seen != 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d required 5", stall_seen); end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes required 0", unstable); end
        n_checks++;
        if (bad_ready != 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d cycles ready required 0", bad_ready); end
        n_checks++;
        if (rows_acc != IMG_H) begin n_fail++; $display("FAIL bp_rows_accepted: got %0d required %0d", rows_acc, IMG_H); end
        n_checks++;
        if (got_rows.size() != NOUT) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", got_rows.size(), NOUT); end
        for (int n = 0; n < got_rows.size() && n < NOUT; n++) begin
            n_checks++;
            if (got_rows[n] !== exp_win(n) || got_idx[n] != n) begin
                n_fail++; $display("FAIL bp_win%0d: got idx %0d %h required idx %0d %h", n, got_idx[n], got_rows[n], n, exp_win(n));
            end
        end
    endtask

    task automatic test_input_gaps();
        fill_img(0);
        run_frame(1, 0, 200);
        n_checks++;
        if (got_rows.size() != NOUT) begin n_fail++; $display("FAIL gaps_count: got %0d required %0d", got_rows.size(), NOUT); end
        for (int n = 0; n < got_rows.size() && n < NOUT; n++) begin
            n_checks++;
            if (got_rows[n] !== exp_win(n) || got_idx[n] != n) begin
                n_fail++; $display("FAIL gaps_win%0d: got idx %0d %h required idx %0d %h", n, got_idx[n], got_rows[n], n, exp_win(n));
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL gaps_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            fill_img(1);
            run_frame(2, 2, 400);
            n_checks++;
            if (got_rows.size() != NOUT || done_cnt != 1) begin
                n_fail++; $display("FAIL rand%0d_frame: got %0d windows %0d done required %0d 1", f, got_rows.size(), done_cnt, NOUT);
            end
            n_checks++;
            if (unstable != 0 || bad_ready != 0) begin
                n_fail++; $display("FAIL rand%0d_hold: got %0d changes %0d ready required 0 0", f, unstable, bad_ready);
            end
            for (int n = 0; n < got_rows.size() && n < NOUT; n++) begin
                n_checks++;
                if (got_rows[n] !== exp_win(n) || got_idx[n] != n) begin
                    n_fail++; $display("FAIL rand%0d_win%0d: got idx %0d %h required idx %0d %h", f, n, got_idx[n], got_rows[n], n, exp_win(n));
                end
            end
        end
    endtask

    task automatic test_abort();
        int cons = 0, t = 0, r = 0, seen = 0;
        fill_img(0);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        bus.in_valid = 1;
        bus.out_ready = 1;
        while (cons < 2 && t < 50) begin
            bus.in_row = pack_row(r < IMG_H ? r : IMG_H - 1);
            #1;
            if (bus.in_valid && bus.in_ready) r++;
            if (bus.out_valid && bus.out_ready) cons++;
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (cons != 2) begin n_fail++; $display("FAIL abort_reach: got %0d windows required 2", cons); end
        clear = 1;
        @(negedge clk);
        clear = 0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: out_valid=%b in_ready=%b required 0 0", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.out_rows !== '0 || bus.out_row_idx !== '0) begin
            n_fail++; $display("FAIL abort_outputs: idx %0d rows %h required 0 0", bus.out_row_idx, bus.out_rows);
        end
        repeat (6) begin
            if (frame_done || bus.out_valid || bus.in_ready) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles required 0", seen); end
        bus.in_valid = 0;
        bus.out_ready = 0;
        run_frame(0, 0, 200);
        n_checks++;
        if (got_rows.size() != NOUT || got_idx[0] != 0) begin
            n_fail++; $display("FAIL abort_restart: got %0d windows first idx %0d required %0d 0", got_rows.size(), got_idx.size() > 0 ? got_idx[0] : -1, NOUT);
        end
        for (int n = 0; n < got_rows.size() && n < NOUT; n++) begin
            n_checks++;
            if (got_rows[n] !== exp_win(n)) begin n_fail++; $display("FAIL abort_win%0d: got %h required %h", n, got_rows[n], exp_win(n)); end
        end
    endtask

`ifdef PAD_VALUE_EN
    task automatic test_pad_value();
        cur_pad = 8'hAA;
        fill_img(1);
        run_frame(0, 0, 200);
        n_checks++;
        if (got_rows.size() != NOUT) begin n_fail++; $display("FAIL pad_count: got %0d required %0d", got_rows.size(), NOUT); end
        for (int n = 0; n < got_rows.size() && n < NOUT; n++) begin
            n_checks++;
            if (got_rows[n] !== exp_win(n)) begin n_fail++; $display("FAIL pad_win%0d: got %h required %h", n, got_rows[n], exp_win(n)); end
        end
        cur_pad = '0;
    endtask
`endif

    initial begin
        bus.in_valid = 0;
        bus.in_row = '0;
        bus.out_ready = 0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_input_gaps();
        test_abort();
        test_random();
`ifdef PAD_VALUE_EN
        test_pad_value();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
